// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and constants for the LC-3 memory arbiter
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_F = 2'd1,
        GNT_D = 2'd2,
        CPL   = 2'd3
    } arb_state_t;

    localparam logic REQ_F = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

endpackage

// File: rtl/lc3_memarb_timer.sv
// rtl/lc3_memarb_timer.sv - 8-bit bus watchdog; expire is high while count == TIMEOUT-1
module lc3_memarb_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - fetch/data arbiter for the LC-3 memory port with timeout watchdog
// Optional macro LC3_MEMARB_RR_EN selects round-robin arbitration instead of fixed D-over-F.
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic [DW-1:0] f_rdata,
    output logic          f_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall,
    output logic          bus_err
);

    arb_state_t state, state_next;
    logic       grant_d;
    logic       in_gnt;
    logic       expire;
    logic       finish;

`ifdef LC3_MEMARB_RR_EN
    logic last_grant;

    always_comb begin
        grant_d = d_req;
        if (d_req && f_req) begin
            grant_d = (last_grant == REQ_F);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= REQ_F;
        end else if (state == IDLE && (d_req || f_req)) begin
            last_grant <= grant_d ? REQ_D : REQ_F;
        end
    end
`else
    always_comb begin
        grant_d = d_req;
    end
`endif

    assign in_gnt = (state == GNT_F) || (state == GNT_D);
    // An ack arriving on the expiry cycle still completes normally.
    assign finish = in_gnt && (mem_ack || expire);

    lc3_memarb_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_gnt),
        .enable (in_gnt && !mem_ack),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (d_req || f_req) begin
                    state_next = grant_d ? GNT_D : GNT_F;
                end
            end
            GNT_F, GNT_D: begin
                if (mem_ack || expire) begin
                    state_next = CPL;
                end
            end
            CPL:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus-side request and transfer latches; F grants never write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= (state_next == GNT_F) || (state_next == GNT_D);
            if (state == IDLE && (d_req || f_req)) begin
                if (grant_d) begin
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= f_addr;
                    mem_wdata <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_rdata <= '0;
            d_rdata <= '0;
            f_done  <= 1'b0;
            d_done  <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            f_done  <= 1'b0;
            d_done  <= 1'b0;
            bus_err <= 1'b0;
            if (finish) begin
                bus_err <= !mem_ack;
                if (state == GNT_F) begin
                    f_done  <= 1'b1;
                    f_rdata <= mem_ack ? mem_rdata : '0;
                end else begin
                    d_done <= 1'b1;
                    if (!mem_we) begin
                        d_rdata <= mem_ack ? mem_rdata : '0;
                    end
                end
            end
        end
    end

    assign stall = (f_req && !f_done) || (d_req && !d_done);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb/tb_lc3_mem_arbiter.sv - directed self-checking bench for lc3_mem_arbiter
module tb_lc3_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req;
    logic [15:0] f_addr;
    logic [15:0] f_rdata;
    logic        f_done;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        bus_err;

    int checks = 0;
    int failures = 0;

    lc3_mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_rdata   (f_rdata),
        .f_done    (f_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    // Advances negedges until mem_req is seen; a missed grant is a failed comparison.
    task automatic wait_grant(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_grant: mem_req=%0b required=1 within 20 cycles", tag, mem_req);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_rdata = 0; mem_ack = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== 34'd0) begin
            failures++;
            $display("FAIL reset_mem: req=%0b we=%0b addr=%h wdata=%h required all 0",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if ({f_rdata, d_rdata, f_done, d_done, bus_err, stall} !== 36'd0) begin
            failures++;
            $display("FAIL reset_out: f_rdata=%h d_rdata=%h f_done=%0b d_done=%0b bus_err=%0b stall=%0b required all 0",
                     f_rdata, d_rdata, f_done, d_done, bus_err, stall);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read;
        d_req = 1; d_we = 0; d_addr = 16'h3000;
        wait_grant("read");
        checks++;
        if (mem_addr !== 16'h3000 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL read_bus: addr=%h we=%0b required 3000/0", mem_addr, mem_we);
        end
        checks++;
        if (stall !== 1'b1 || d_done !== 1'b0) begin
            failures++;
            $display("FAIL read_wait: stall=%0b d_done=%0b required 1/0", stall, d_done);
        end
        @(negedge clk);
        mem_ack = 1; mem_rdata = 16'hBEEF;
        @(negedge clk);
        mem_ack = 0; mem_rdata = 16'h0000;
        checks++;
        if (d_done !== 1'b1 || d_rdata !== 16'hBEEF || stall !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL read_done: d_done=%0b d_rdata=%h stall=%0b mem_req=%0b required 1/BEEF/0/0",
                     d_done, d_rdata, stall, mem_req);
        end
        d_req = 0;
        @(negedge clk);
        checks++;
        if (d_done !== 1'b0 || d_rdata !== 16'hBEEF) begin
            failures++;
            $display("FAIL read_pulse: d_done=%0b d_rdata=%h required 0/BEEF", d_done, d_rdata);
        end
    endtask

    task automatic test_priority;
        int d_cyc;
        int cyc;
        f_req = 1; f_addr = 16'h0200;
        d_req = 1; d_we = 1; d_addr = 16'h3010; d_wdata = 16'h1234;
        wait_grant("prio_d");
        checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 16'h1234 || mem_addr !== 16'h3010) begin
            failures++;
            $display("FAIL prio_d_bus: we=%0b wdata=%h addr=%h required 1/1234/3010",
                     mem_we, mem_wdata, mem_addr);
        end
        mem_ack = 1; mem_rdata = 16'h5555;
        @(negedge clk);
        mem_ack = 0;
        checks++;
        if (d_done !== 1'b1 || f_done !== 1'b0 || d_rdata !== 16'hBEEF || f_rdata !== 16'h0000 || stall !== 1'b1) begin
            failures++;
            $display("FAIL prio_d_done: d_done=%0b f_done=%0b d_rdata=%h f_rdata=%h stall=%0b required 1/0/BEEF/0000/1",
                     d_done, f_done, d_rdata, f_rdata, stall);
        end
        d_req = 0; d_we = 0;
        d_cyc = 0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (mem_req) begin
                mem_ack = 1; mem_rdata = 16'hCAFE;
            end
            if (f_done) begin
                d_cyc = cyc;
                break;
            end
        end
        mem_ack = 0;
        checks++;
        if (d_cyc < 3) begin
            failures++;
            $display("FAIL prio_f_gap: f_done after %0d cycles required >=3", d_cyc);
        end
        checks++;
        if (f_rdata !== 16'hCAFE || mem_we !== 1'b0 || mem_wdata !== 16'h0000 || mem_addr !== 16'h0200) begin
            failures++;
            $display("FAIL prio_f_bus: f_rdata=%h we=%0b wdata=%h addr=%h required CAFE/0/0000/0200",
                     f_rdata, mem_we, mem_wdata, mem_addr);
        end
        f_req = 0;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int n;
        n = 0;
        d_req = 1; d_we = 0; d_addr = 16'h3100;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_req) n++;
            else if (n > 0) break;
        end
        checks++;
        if (n !== 15) begin
            failures++;
            $display("FAIL timeout_len: grant cycles=%0d required 15", n);
        end
        checks++;
        if (bus_err !== 1'b1 || d_done !== 1'b1 || d_rdata !== 16'h0000 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL timeout_cpl: bus_err=%0b d_done=%0b d_rdata=%h mem_req=%0b required 1/1/0000/0",
                     bus_err, d_done, d_rdata, mem_req);
        end
        d_req = 0;
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse: bus_err=%0b required 0", bus_err);
        end
    endtask

    task automatic test_ack_at_timeout;
        int n;
        n = 0;
        d_req = 1; d_we = 0; d_addr = 16'h3200;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_req) begin
                n++;
                if (n == 15) begin
                    mem_ack = 1; mem_rdata = 16'h1357;
                    break;
                end
            end
        end
        @(negedge clk);
        mem_ack = 0;
        checks++;
        if (bus_err !== 1'b0 || d_done !== 1'b1 || d_rdata !== 16'h1357) begin
            failures++;
            $display("FAIL ack_timeout: bus_err=%0b d_done=%0b d_rdata=%h required 0/1/1357",
                     bus_err, d_done, d_rdata);
        end
        d_req = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_grant;
        f_req = 1; f_addr = 16'h0400;
        wait_grant("rst_f");
        #2 reset = 1;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: mem_req=%0b required 0", mem_req);
        end
        @(negedge clk);
        checks++;
        if (f_done !== 1'b0 || f_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL rst_nodone: f_done=%0b f_rdata=%h required 0/0000", f_done, f_rdata);
        end
        reset = 0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0400 || f_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_regrant: mem_req=%0b addr=%h f_done=%0b required 1/0400/0",
                     mem_req, mem_addr, f_done);
        end
        mem_ack = 1; mem_rdata = 16'h0F0F;
        @(negedge clk);
        mem_ack = 0;
        checks++;
        if (f_done !== 1'b1 || f_rdata !== 16'h0F0F) begin
            failures++;
            $display("FAIL rst_complete: f_done=%0b f_rdata=%h required 1/0F0F", f_done, f_rdata);
        end
        f_req = 0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_addr [4];
`ifdef LC3_MEMARB_RR_EN
        exp_addr = '{16'h3300, 16'h0500, 16'h3300, 16'h0500};
`else
        exp_addr = '{16'h3300, 16'h3300, 16'h3300, 16'h3300};
`endif
        f_req = 1; f_addr = 16'h0500;
        d_req = 1; d_we = 0; d_addr = 16'h3300;
        for (int g = 0; g < 4; g++) begin
            wait_grant("b2b");
            checks++;
            if (mem_addr !== exp_addr[g]) begin
                failures++;
                $display("FAIL b2b_order%0d: mem_addr=%h required %h", g, mem_addr, exp_addr[g]);
            end
            mem_ack = 1; mem_rdata = 16'hA000 + 16'(g);
            @(negedge clk);
            mem_ack = 0;
        end
        f_req = 0; d_req = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: mem_req=%0b stall=%0b required 0/0", mem_req, stall);
        end
    endtask

    initial begin
        test_reset;
        test_read;
        test_priority;
        test_timeout;
        test_ack_at_timeout;
        test_reset_mid_grant;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
